intra16_mode_decide: RTL and testbench
======================================

INTRA16_MODE_DECIDE -- requirements
Module: intra16_mode_decide

Interface
REQ-001 Parameter PIX_W, default 8, sample bit width.
REQ-002 Parameter SAD_W, default PIX_W+8, accumulator width; sized so 256*(2^PIX_W-1) never overflows.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  row-beat valid.
REQ-006 in_ready  output  1  block can accept a row beat.
REQ-007 in_first  input  1  beat carries row 0 of a macroblock.
REQ-008 orig_row  input  16*PIX_W  original samples, column 0 in LSBs.
REQ-009 vpred_row, hpred_row, dcpred_row  input  16*PIX_W each  vertical, horizontal and DC prediction rows, same packing.
REQ-010 out_valid  output  1  decision valid.
REQ-011 out_ready  input  1  consumer accepts decision.
REQ-012 best_mode  output  2  0=V, 1=H, 2=DC; 3 never driven.
REQ-013 best_sad, sad_v, sad_h, sad_dc  output  SAD_W each  winning SAD and the three per-mode SADs.
REQ-014 err_sync  output  1  sticky flag for a row-sequencing violation.

Function
REQ-015 FSM states: ACCUM and DONE; in_ready SHALL equal (state==ACCUM); out_valid SHALL equal (state==DONE).
REQ-016 Beat accepted when in_valid && in_ready; only accepted beats update counters and accumulators.
REQ-017 Per accepted beat: row SAD per mode = sum over 16 columns of |orig - pred|, unsigned, computed combinationally, added to that mode's accumulator.
REQ-018 4-bit row counter increments per accepted beat; the beat accepted with counter==15 completes the block.
REQ-019 Completing beat: accumulators take final sums, best_mode/best_sad registered, state -> DONE; out_valid high on the next cycle (latency 1 cycle after the 16th row).
REQ-020 Selection: minimum SAD; ties resolved V over H over DC.
REQ-021 DONE: outputs held stable and in_ready low until out_valid && out_ready; that cycle state -> ACCUM, counter and accumulators cleared.
REQ-022 in_first accepted with counter==0: normal row 0.
REQ-023 in_first accepted with counter!=0: err_sync set; partial block discarded; accumulators load this beat's row SAD, counter -> 1.
REQ-024 in_first low on an accepted beat with counter==0: accepted as row 0, no error.
REQ-025 err_sync cleared only by reset.
REQ-026 in_valid while in DONE: ignored, no state change.
REQ-027 out_ready while in ACCUM: ignored.

Reset
REQ-028 On reset: state ACCUM, counter 0, all accumulators 0, best_mode 0, best_sad/sad_* 0, out_valid 0, err_sync 0.
REQ-029 Reset mid-block or in DONE: partial or pending result discarded, no out_valid; first beat after reset treated as row 0.

Structure
REQ-030 Shared package intra_pkg holds PIX_W default, MB_SIZE=16, mode encodings MODE_V/MODE_H/MODE_DC and the FSM state type.
REQ-031 One sub-module, sad_row16: purely combinational 16-sample absolute-difference adder tree, instantiated three times.

Verification
REQ-032 16 rows, orig=all 100, vpred=100, hpred=101, dcpred=98 -> sad_v=0, sad_h=256, sad_dc=512, best_mode=0, out_valid one cycle after row 16.
REQ-033 All preds equal, orig-pred=5 per sample -> three SADs 1280, best_mode=0 (tie rule).
REQ-034 orig=255, vpred=0, hpred=0, dcpred=254 -> sad_v=65280 (no overflow), sad_dc=256, best_mode=2.
REQ-035 out_ready held low 10 cycles in DONE with in_valid high -> outputs stable, in_ready low, no beats consumed; release -> next block accepted from row 0.
REQ-036 in_first on row 7 -> err_sync=1; decision issued after 15 further rows, using only the restarted block.
REQ-037 reset asserted at row 9 -> all outputs at reset values next cycle; next 16 rows yield one correct decision.

Source files
------------

// File: rtl/intra16_mode_decide_pkg.sv
// Shared definitions for the 16x16 intra mode decision block: sizes,
// prediction mode encodings and the decision FSM state type.
package intra_pkg;

    localparam int PIX_W_DEFAULT = 8;
    localparam int MB_SIZE       = 16;
    localparam int CNT_W         = $clog2(MB_SIZE);

    localparam logic [1:0] MODE_V  = 2'd0;
    localparam logic [1:0] MODE_H  = 2'd1;
    localparam logic [1:0] MODE_DC = 2'd2;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

endpackage

// File: rtl/intra16_mode_decide_sad_row16.sv
// Combinational sum of absolute differences across one 16-sample row.
// Columns are packed with column 0 in the least significant bits.
module sad_row16
    import intra_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEFAULT,
    parameter int OUT_W = PIX_W + 4
) (
    input  logic [MB_SIZE*PIX_W-1:0] orig_row,
    input  logic [MB_SIZE*PIX_W-1:0] pred_row,
    output logic [OUT_W-1:0]         row_sad
);

    logic [OUT_W-1:0] diff [MB_SIZE];
    logic [OUT_W-1:0] lvl1 [8];
    logic [OUT_W-1:0] lvl2 [4];
    logic [OUT_W-1:0] lvl3 [2];

    for (genvar i = 0; i < MB_SIZE; i++) begin : g_absdiff
        logic [PIX_W-1:0] a;
        logic [PIX_W-1:0] b;
        assign a = orig_row[i*PIX_W +: PIX_W];
        assign b = pred_row[i*PIX_W +: PIX_W];
        assign diff[i] = (a >= b) ? OUT_W'(a - b) : OUT_W'(b - a);
    end

    // Balanced adder tree so the row SAD settles in log2(16) adder levels
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lvl1[i] = diff[2*i] + diff[2*i+1];
        end
        for (int i = 0; i < 4; i++) begin
            lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
        end
        for (int i = 0; i < 2; i++) begin
            lvl3[i] = lvl2[2*i] + lvl2[2*i+1];
        end
        row_sad = lvl3[0] + lvl3[1];
    end

endmodule

// File: rtl/intra16_mode_decide.sv
// Accumulates per-mode SADs over the 16 rows of a macroblock and picks the
// cheapest of vertical, horizontal and DC prediction.
module intra16_mode_decide
    import intra_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEFAULT,
    parameter int SAD_W = PIX_W + 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic [MB_SIZE*PIX_W-1:0] orig_row,
    input  logic [MB_SIZE*PIX_W-1:0] vpred_row,
    input  logic [MB_SIZE*PIX_W-1:0] hpred_row,
    input  logic [MB_SIZE*PIX_W-1:0] dcpred_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               best_mode,
    output logic [SAD_W-1:0]         best_sad,
    output logic [SAD_W-1:0]         sad_v,
    output logic [SAD_W-1:0]         sad_h,
    output logic [SAD_W-1:0]         sad_dc,
    output logic                     err_sync
);

    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(MB_SIZE - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] row_cnt;
    logic [SAD_W-1:0] acc_v, acc_h, acc_dc;
    logic [SAD_W-1:0] row_v, row_h, row_dc;
    logic [SAD_W-1:0] base_v, base_h, base_dc;
    logic [SAD_W-1:0] sum_v, sum_h, sum_dc;
    logic [1:0]       sel_mode;
    logic [SAD_W-1:0] sel_sad;
    logic             accept;
    logic             restart;
    logic             complete;

    sad_row16 #(.PIX_W(PIX_W), .OUT_W(SAD_W)) u_sad_v (
        .orig_row (orig_row),
        .pred_row (vpred_row),
        .row_sad  (row_v)
    );

    sad_row16 #(.PIX_W(PIX_W), .OUT_W(SAD_W)) u_sad_h (
        .orig_row (orig_row),
        .pred_row (hpred_row),
        .row_sad  (row_h)
    );

    sad_row16 #(.PIX_W(PIX_W), .OUT_W(SAD_W)) u_sad_dc (
        .orig_row (orig_row),
        .pred_row (dcpred_row),
        .row_sad  (row_dc)
    );

    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    // A row-0 marker arriving mid-block abandons the partial block and
    // restarts accumulation from this beat.
    assign restart   = accept && in_first && (row_cnt != '0);
    assign complete  = accept && !restart && (row_cnt == LAST_ROW);

    assign sad_v  = acc_v;
    assign sad_h  = acc_h;
    assign sad_dc = acc_dc;

    // Running sums including the current row, rebased to zero on a restart
    always_comb begin
        base_v  = restart ? '0 : acc_v;
        base_h  = restart ? '0 : acc_h;
        base_dc = restart ? '0 : acc_dc;
        sum_v   = base_v + row_v;
        sum_h   = base_h + row_h;
        sum_dc  = base_dc + row_dc;
    end

    // Strict less-than comparisons give V priority over H over DC on ties
    always_comb begin
        sel_mode = MODE_V;
        sel_sad  = sum_v;
        if (sum_h < sel_sad) begin
            sel_mode = MODE_H;
            sel_sad  = sum_h;
        end
        if (sum_dc < sel_sad) begin
            sel_mode = MODE_DC;
            sel_sad  = sum_dc;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Leave ACCUM on the 16th row, leave DONE once the decision is taken
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCUM: if (complete)  state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) state_nxt = ST_ACCUM;
            default:                 state_nxt = ST_ACCUM;
        endcase
    end

    // Row counter, accumulators, registered decision and sticky sync error
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt   <= '0;
            acc_v     <= '0;
            acc_h     <= '0;
            acc_dc    <= '0;
            best_mode <= MODE_V;
            best_sad  <= '0;
            err_sync  <= 1'b0;
        end else if (state == ST_DONE) begin
            if (out_ready) begin
                row_cnt <= '0;
                acc_v   <= '0;
                acc_h   <= '0;
                acc_dc  <= '0;
            end
        end else if (accept) begin
            acc_v   <= sum_v;
            acc_h   <= sum_h;
            acc_dc  <= sum_dc;
            row_cnt <= restart ? CNT_W'(1) : row_cnt + 1'b1;
            if (restart) begin
                err_sync <= 1'b1;
            end
            if (complete) begin
                best_mode <= sel_mode;
                best_sad  <= sel_sad;
            end
        end
    end

endmodule

// File: tb/tb_intra16_mode_decide.sv
// Directed self-checking bench for intra16_mode_decide.
module tb_intra16_mode_decide;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic [127:0] orig_row;
    logic [127:0] vpred_row;
    logic [127:0] hpred_row;
    logic [127:0] dcpred_row;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   best_mode;
    logic [15:0]  best_sad;
    logic [15:0]  sad_v;
    logic [15:0]  sad_h;
    logic [15:0]  sad_dc;
    logic         err_sync;

    int errors = 0;
    int checks = 0;

    intra16_mode_decide #(.PIX_W(8), .SAD_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_first   (in_first),
        .orig_row   (orig_row),
        .vpred_row  (vpred_row),
        .hpred_row  (hpred_row),
        .dcpred_row (dcpred_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .best_mode  (best_mode),
        .best_sad   (best_sad),
        .sad_v      (sad_v),
        .sad_h      (sad_h),
        .sad_dc     (sad_dc),
        .err_sync   (err_sync)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] fill(input logic [7:0] v);
        return {16{v}};
    endfunction

    function automatic logic [127:0] ramp(input int base, input int step);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(base + step * i);
        return r;
    endfunction

    // Present one row beat at a falling edge and let one rising edge pass
    task automatic applyStimulus(input logic [127:0] o, input logic [127:0] v,
                                 input logic [127:0] h, input logic [127:0] d,
                                 input logic first);
        in_valid   = 1'b1;
        in_first   = first;
        orig_row   = o;
        vpred_row  = v;
        hpred_row  = h;
        dcpred_row = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (best_mode !== 2'd0 || best_sad !== 16'd0) begin errors++; $display("[TB] FAIL reset_best: got mode %0d sad %0d expected 0 0", best_mode, best_sad); end
        checks++; if (sad_v !== 16'd0 || sad_h !== 16'd0 || sad_dc !== 16'd0) begin errors++; $display("[TB] FAIL reset_sads: got %0d %0d %0d expected 0 0 0", sad_v, sad_h, sad_dc); end
        checks++; if (err_sync !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_sync: got %0b expected 0", err_sync); end
    endtask

    // orig 100 against V=100, H=101, DC=98, checking the one-cycle latency
    task automatic test_basic();
        for (int r = 0; r < 15; r++) applyStimulus(fill(100), fill(100), fill(101), fill(98), r == 0);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_row15: got valid %0b ready %0b expected 0 1", out_valid, in_ready); end
        applyStimulus(fill(100), fill(100), fill(101), fill(98), 1'b0);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_latency: got valid %0b ready %0b expected 1 0", out_valid, in_ready); end
        checks++; if (sad_v !== 16'd0 || sad_h !== 16'd256 || sad_dc !== 16'd512) begin errors++; $display("[TB] FAIL basic_sads: got %0d %0d %0d expected 0 256 512", sad_v, sad_h, sad_dc); end
        checks++; if (best_mode !== 2'd0 || best_sad !== 16'd0) begin errors++; $display("[TB] FAIL basic_best: got mode %0d sad %0d expected 0 0", best_mode, best_sad); end
        checks++; if (err_sync !== 1'b0) begin errors++; $display("[TB] FAIL basic_err_sync: got %0b expected 0", err_sync); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sad_h !== 16'd0) begin errors++; $display("[TB] FAIL basic_release: got valid %0b ready %0b sad_h %0d expected 0 1 0", out_valid, in_ready, sad_h); end
    endtask

    // All three predictors equal, so the three-way tie must pick V
    task automatic test_tie_all();
        for (int r = 0; r < 16; r++) applyStimulus(fill(105), fill(100), fill(100), fill(100), r == 0);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL tie_valid: got %0b expected 1", out_valid); end
        checks++; if (sad_v !== 16'd1280 || sad_h !== 16'd1280 || sad_dc !== 16'd1280) begin errors++; $display("[TB] FAIL tie_sads: got %0d %0d %0d expected 1280 1280 1280", sad_v, sad_h, sad_dc); end
        checks++; if (best_mode !== 2'd0 || best_sad !== 16'd1280) begin errors++; $display("[TB] FAIL tie_best: got mode %0d sad %0d expected 0 1280", best_mode, best_sad); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    // H and DC tie below V, so H must win
    task automatic test_tie_h_dc();
        for (int r = 0; r < 16; r++) applyStimulus(fill(100), fill(90), fill(95), fill(105), r == 0);
        in_valid = 1'b0;
        checks++; if (sad_v !== 16'd2560 || sad_h !== 16'd1280 || sad_dc !== 16'd1280) begin errors++; $display("[TB] FAIL tiehdc_sads: got %0d %0d %0d expected 2560 1280 1280", sad_v, sad_h, sad_dc); end
        checks++; if (best_mode !== 2'd1 || best_sad !== 16'd1280) begin errors++; $display("[TB] FAIL tiehdc_best: got mode %0d sad %0d expected 1 1280", best_mode, best_sad); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    // Full-scale differences reach 65280 without wrapping; DC wins
    task automatic test_overflow();
        for (int r = 0; r < 16; r++) applyStimulus(fill(255), fill(0), fill(0), fill(254), r == 0);
        in_valid = 1'b0;
        checks++; if (sad_v !== 16'd65280 || sad_h !== 16'd65280 || sad_dc !== 16'd256) begin errors++; $display("[TB] FAIL ovf_sads: got %0d %0d %0d expected 65280 65280 256", sad_v, sad_h, sad_dc); end
        checks++; if (best_mode !== 2'd2 || best_sad !== 16'd256) begin errors++; $display("[TB] FAIL ovf_best: got mode %0d sad %0d expected 2 256", best_mode, best_sad); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    // Per-column varying samples with predictions on both sides of orig
    task automatic test_columns();
        for (int r = 0; r < 16; r++) applyStimulus(ramp(0, 10), fill(0), fill(75), ramp(150, -10), r == 0);
        in_valid = 1'b0;
        checks++; if (sad_v !== 16'd19200 || sad_h !== 16'd10240 || sad_dc !== 16'd20480) begin errors++; $display("[TB] FAIL cols_sads: got %0d %0d %0d expected 19200 10240 20480", sad_v, sad_h, sad_dc); end
        checks++; if (best_mode !== 2'd1 || best_sad !== 16'd10240) begin errors++; $display("[TB] FAIL cols_best: got mode %0d sad %0d expected 1 10240", best_mode, best_sad); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    // Decision held for 10 cycles while upstream keeps offering beats
    task automatic test_back_to_back();
        for (int r = 0; r < 16; r++) applyStimulus(fill(100), fill(100), fill(101), fill(98), r == 0);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(fill(0), fill(255), fill(255), fill(255), 1'b1);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sad_v !== 16'd0 || sad_h !== 16'd256 ||
                sad_dc !== 16'd512 || best_mode !== 2'd0 || best_sad !== 16'd0) begin
                errors++;
                $display("[TB] FAIL stall_hold cycle %0d: got valid %0b ready %0b sads %0d %0d %0d mode %0d best %0d expected 1 0 0 256 512 0 0",
                         c, out_valid, in_ready, sad_v, sad_h, sad_dc, best_mode, best_sad);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        for (int r = 0; r < 15; r++) applyStimulus(fill(105), fill(100), fill(100), fill(100), r == 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_next_row15: got %0b expected 0", out_valid); end
        applyStimulus(fill(105), fill(100), fill(100), fill(100), 1'b0);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || sad_v !== 16'd1280 || sad_dc !== 16'd1280) begin errors++; $display("[TB] FAIL stall_next_block: got valid %0b sad_v %0d sad_dc %0d expected 1 1280 1280", out_valid, sad_v, sad_dc); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    // in_first on row 7 restarts the block and latches the sticky error
    task automatic test_resync();
        for (int r = 0; r < 7; r++) applyStimulus(fill(100), fill(0), fill(0), fill(0), r == 0);
        checks++; if (err_sync !== 1'b0) begin errors++; $display("[TB] FAIL resync_pre: got %0b expected 0", err_sync); end
        applyStimulus(fill(100), fill(100), fill(101), fill(98), 1'b1);
        checks++; if (err_sync !== 1'b1) begin errors++; $display("[TB] FAIL resync_flag: got %0b expected 1", err_sync); end
        for (int r = 0; r < 14; r++) applyStimulus(fill(100), fill(100), fill(101), fill(98), 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL resync_early: got %0b expected 0", out_valid); end
        applyStimulus(fill(100), fill(100), fill(101), fill(98), 1'b0);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || sad_v !== 16'd0 || sad_h !== 16'd256 || sad_dc !== 16'd512) begin errors++; $display("[TB] FAIL resync_result: got valid %0b sads %0d %0d %0d expected 1 0 256 512", out_valid, sad_v, sad_h, sad_dc); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        checks++; if (err_sync !== 1'b1) begin errors++; $display("[TB] FAIL resync_sticky: got %0b expected 1", err_sync); end
    endtask

    // Reset in the middle of a block, then a block with in_first never set
    task automatic test_reset_midblock();
        for (int r = 0; r < 9; r++) applyStimulus(fill(100), fill(0), fill(0), fill(0), r == 0);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_sync !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ctrl: got valid %0b ready %0b err %0b expected 0 1 0", out_valid, in_ready, err_sync); end
        checks++; if (sad_v !== 16'd0 || sad_h !== 16'd0 || sad_dc !== 16'd0 || best_sad !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_sads: got %0d %0d %0d best %0d expected 0 0 0 0", sad_v, sad_h, sad_dc, best_sad); end
        for (int r = 0; r < 16; r++) applyStimulus(fill(100), fill(100), fill(101), fill(98), 1'b0);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || sad_v !== 16'd0 || sad_h !== 16'd256 || sad_dc !== 16'd512) begin errors++; $display("[TB] FAIL rstmid_result: got valid %0b sads %0d %0d %0d expected 1 0 256 512", out_valid, sad_v, sad_h, sad_dc); end
        checks++; if (best_mode !== 2'd0 || err_sync !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_best: got mode %0d err %0b expected 0 0", best_mode, err_sync); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    // Scenario sequence
    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_first   = 1'b0;
        out_ready  = 1'b0;
        orig_row   = '0;
        vpred_row  = '0;
        hpred_row  = '0;
        dcpred_row = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_tie_all();
        test_tie_h_dc();
        test_overflow();
        test_columns();
        test_back_to_back();
        test_resync();
        test_reset_midblock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
